// File: rtl/field_pkg.sv
// ============================================================================
//  Module      : field_pkg
//  Description : Shared widths, game states and helpers for asteroid_field.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package field_pkg;

    localparam int XW     = 10;
    localparam int YW     = 11;
    localparam int CW     = YW + 1;
    localparam int IW     = 3;
    localparam int LFSR_W = 9;

    // Feedback taps q[8]^q[6]^q[5]^q[4]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 9'b1_0111_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Two-digit BCD increment that holds at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99)
            r = s;
        else if (s[3:0] == 4'd9)
            r = {s[7:4] + 4'd1, 4'd0};
        else
            r = {s[7:4], s[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [IW-1:0] prio_idx(input logic [7:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i])
                idx = IW'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/asteroid_field_slot.sv
// ============================================================================
//  Module      : asteroid_slot
//  Description : One asteroid: position registers, bullet overlap and pixel test.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asteroid_slot
    import field_pkg::*;
#(
    parameter int SIZE     = 25,
    parameter int SPEED    = 1,
    parameter int GROUND_Y = 450,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = -25
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 advance,
    input  logic                 respawn,
    input  logic [XW-1:0]        spawn_x,
    input  logic                 bullet_valid,
    input  logic [XW-1:0]        bullet_x1,
    input  logic [XW-1:0]        bullet_x2,
    input  logic signed [YW-1:0] bullet_y1,
    input  logic signed [YW-1:0] bullet_y2,
    input  logic [XW-1:0]        px,
    input  logic [XW-1:0]        py,
    output logic                 overlap,
    output logic                 covers,
    output logic                 grounded
);

    localparam logic [XW-1:0]        C_INIT_X  = XW'(INIT_X);
    localparam logic signed [YW-1:0] C_INIT_Y  = YW'(INIT_Y);
    localparam logic signed [YW-1:0] C_SPAWN_Y = YW'(-SIZE);
    localparam logic signed [YW-1:0] C_SPEED   = YW'(SPEED);
    localparam logic signed [CW-1:0] C_SIZE    = CW'(SIZE);
    localparam logic signed [CW-1:0] C_STEP    = CW'(SPEED);
    localparam logic signed [CW-1:0] C_GROUND  = CW'(GROUND_Y);

    logic [XW-1:0]        r_x1;
    logic signed [YW-1:0] r_y1;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            r_x1 <= C_INIT_X;
            r_y1 <= C_INIT_Y;
        end else if (respawn) begin
            r_x1 <= spawn_x;
            r_y1 <= C_SPAWN_Y;
        end else if (advance) begin
            r_y1 <= r_y1 + C_SPEED;
        end
    end

    // All compares in one signed width wide enough for x2/y2 and pixel coords
    logic signed [CW-1:0] w_ax1, w_ax2, w_ay1, w_ay2;
    logic signed [CW-1:0] w_bx1, w_bx2, w_by1, w_by2;
    logic signed [CW-1:0] w_px, w_py;

    assign w_ax1 = $signed({2'b00, r_x1});
    assign w_ax2 = w_ax1 + C_SIZE;
    assign w_ay1 = {r_y1[YW-1], r_y1};
    assign w_ay2 = w_ay1 + C_SIZE;
    assign w_bx1 = $signed({2'b00, bullet_x1});
    assign w_bx2 = $signed({2'b00, bullet_x2});
    assign w_by1 = {bullet_y1[YW-1], bullet_y1};
    assign w_by2 = {bullet_y2[YW-1], bullet_y2};
    assign w_px  = $signed({2'b00, px});
    assign w_py  = $signed({2'b00, py});

    assign overlap  = bullet_valid && (w_bx2 > w_ax1) && (w_bx1 < w_ax2)
                      && (w_by1 < w_ay2) && (w_by2 > w_ay1);
    assign covers   = (w_px > w_ax1) && (w_px < w_ax2) && (w_py > w_ay1) && (w_py < w_ay2);
    assign grounded = (w_ay1 + C_STEP) >= C_GROUND;

endmodule

`default_nettype wire

// File: rtl/asteroid_field.sv
// ============================================================================
//  Module      : asteroid_field
//  Description : N falling asteroids with bullet collision, LFSR respawn,
//                BCD score, game state machine and a pixel-lookup port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asteroid_field
    import field_pkg::*;
#(
    parameter int               N_AST     = 4,
    parameter int               SIZE      = 25,
    parameter int               SPEED     = 1,
    parameter int               SCREEN_W  = 640,
    parameter int               GROUND_Y  = 450,
    parameter int               X0        = 100,
    parameter int               X_STEP    = 90,
    parameter int               Y_STAGGER = 75,
    parameter logic [8:0]       LFSR_SEED = 9'h1A5
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 move_tick,
    input  logic                 bullet_valid,
    input  logic [XW-1:0]        bullet_x1,
    input  logic [XW-1:0]        bullet_x2,
    input  logic signed [YW-1:0] bullet_y1,
    input  logic signed [YW-1:0] bullet_y2,
    input  logic [XW-1:0]        px,
    input  logic [XW-1:0]        py,
    output logic                 pix_obj,
    output logic [IW-1:0]        pix_idx,
    output logic                 hit,
    output logic [IW-1:0]        hit_idx,
    output logic                 bullet_kill,
    output logic [3:0]           score_ones,
    output logic [3:0]           score_tens,
    output logic                 game_over,
    output logic                 playing
);

    localparam int SPAN = SCREEN_W - SIZE;

    state_t              r_state, w_state_next;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [7:0]          r_score;
    logic                r_hit;
    logic [IW-1:0]       r_hit_idx;
    logic                r_pix_obj;
    logic [IW-1:0]       r_pix_idx;

    logic [N_AST-1:0]    w_overlap, w_covers, w_grounded, w_hit_sel;
    logic [IW-1:0]       w_hit_idx, w_pix_idx;
    logic [XW-1:0]       w_lfsr_ext, w_spawn_x;
    logic                w_tick, w_init, w_any_hit, w_ground;

    assign w_tick    = (r_state == PLAY) && move_tick;
    assign w_init    = start && (r_state != PLAY);
    assign w_any_hit = |w_overlap;
    assign w_hit_idx = prio_idx(8'(w_overlap));
    assign w_pix_idx = prio_idx(8'(w_covers));
    // A respawning asteroid cannot end the game on the tick it is destroyed
    assign w_ground  = |(w_grounded & ~w_hit_sel);

    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
    end

    assign w_lfsr_ext = {1'b0, r_lfsr};
    assign w_spawn_x  = (w_lfsr_ext < XW'(SPAN)) ? w_lfsr_ext : w_lfsr_ext - XW'(SPAN);

    generate
        for (genvar gi = 0; gi < N_AST; gi++) begin : g_slot
            assign w_hit_sel[gi] = w_overlap[gi] && (w_hit_idx == IW'(gi));

            asteroid_slot #(
                .SIZE     (SIZE),
                .SPEED    (SPEED),
                .GROUND_Y (GROUND_Y),
                .INIT_X   (X0 + gi * X_STEP),
                .INIT_Y   (-SIZE - gi * Y_STAGGER)
            ) u_slot (
                .clk          (clk),
                .reset        (reset),
                .init         (w_init),
                .advance      (w_tick && !w_hit_sel[gi]),
                .respawn      (w_tick && w_hit_sel[gi]),
                .spawn_x      (w_spawn_x),
                .bullet_valid (bullet_valid),
                .bullet_x1    (bullet_x1),
                .bullet_x2    (bullet_x2),
                .bullet_y1    (bullet_y1),
                .bullet_y2    (bullet_y2),
                .px           (px),
                .py           (py),
                .overlap      (w_overlap[gi]),
                .covers       (w_covers[gi]),
                .grounded     (w_grounded[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = PLAY;
            PLAY:    if (w_tick && w_ground) w_state_next = OVER;
            OVER:    if (start) w_state_next = PLAY;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_score   <= '0;
            r_pix_obj <= 1'b0;
            r_pix_idx <= '0;
        end else begin
            r_hit     <= w_tick && w_any_hit;
            r_hit_idx <= (w_tick && w_any_hit) ? w_hit_idx : '0;
            if (w_init)
                r_score <= '0;
            else if (w_tick && w_any_hit)
                r_score <= bcd_inc(r_score);
            r_pix_obj <= (r_state != IDLE) && (|w_covers);
            r_pix_idx <= ((r_state != IDLE) && (|w_covers)) ? w_pix_idx : '0;
        end
    end

    assign hit         = r_hit;
    assign hit_idx     = r_hit_idx;
    assign bullet_kill = r_hit;
    assign score_ones  = r_score[3:0];
    assign score_tens  = r_score[7:4];
    assign pix_obj     = r_pix_obj;
    assign pix_idx     = r_pix_idx;
    assign game_over   = (r_state == OVER);
    assign playing     = (r_state == PLAY);

endmodule

`default_nettype wire

// File: tb/tb_asteroid_field.sv
// ============================================================================
//  Module      : tb_asteroid_field
//  Description : Scoreboard bench for asteroid_field against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asteroid_field;

    localparam int N      = 4;
    localparam int SIZE   = 25;
    localparam int SPEED  = 1;
    localparam int SPAN   = 640 - 25;
    localparam int GROUND = 450;
    localparam logic [8:0] SEED = 9'h1A5;
    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_OVER = 2;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] score;
        logic       over;
        logic       play;
    } exp_t;

    typedef struct packed {
        logic       obj;
        logic [2:0] idx;
    } pix_t;

    logic clk = 1'b0;
    logic reset, start, move_tick, bullet_valid;
    logic [9:0] bullet_x1, bullet_x2, px, py;
    logic signed [10:0] bullet_y1, bullet_y2;
    logic pix_obj, hit, bullet_kill, game_over, playing;
    logic [2:0] pix_idx, hit_idx;
    logic [3:0] score_ones, score_tens;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    pix_t pq[$];

    int m_x[N];
    int m_y[N];
    int m_state;
    int m_score;
    logic [8:0] m_lfsr;

    always #5 clk = ~clk;

    asteroid_field #(
        .N_AST(N), .SIZE(SIZE), .SPEED(SPEED), .SCREEN_W(640), .GROUND_Y(GROUND),
        .X0(100), .X_STEP(90), .Y_STAGGER(75), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .move_tick(move_tick),
        .bullet_valid(bullet_valid), .bullet_x1(bullet_x1), .bullet_x2(bullet_x2),
        .bullet_y1(bullet_y1), .bullet_y2(bullet_y2), .px(px), .py(py),
        .pix_obj(pix_obj), .pix_idx(pix_idx), .hit(hit), .hit_idx(hit_idx),
        .bullet_kill(bullet_kill), .score_ones(score_ones), .score_tens(score_tens),
        .game_over(game_over), .playing(playing)
    );

    always @(posedge clk) begin
        if (reset)
            m_lfsr <= SEED;
        else
            m_lfsr <= {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[6] ^ m_lfsr[5] ^ m_lfsr[4]};
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic void model_init();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 100 + i * 90;
            m_y[i] = -SIZE - i * 75;
        end
    endfunction

    function automatic exp_t make_exp(input int hi);
        exp_t e;
        e.hit   = (hi >= 0);
        e.idx   = (hi >= 0) ? 3'(hi) : 3'd0;
        e.score = to_bcd(m_score);
        e.over  = (m_state == S_OVER);
        e.play  = (m_state == S_PLAY);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        check_value("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_value("hit", 32'(hit), 32'(e.hit));
            check_value("bullet_kill", 32'(bullet_kill), 32'(e.hit));
            if (e.hit)
                check_value("hit_idx", 32'(hit_idx), 32'(e.idx));
            check_value("score", 32'({score_tens, score_ones}), 32'(e.score));
            check_value("game_over", 32'(game_over), 32'(e.over));
            check_value("playing", 32'(playing), 32'(e.play));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_init();
        m_state = S_IDLE;
        m_score = 0;
        sb.push_back(make_exp(-1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_out();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        if (m_state != S_PLAY) begin
            model_init();
            m_score = 0;
            m_state = S_PLAY;
        end
        sb.push_back(make_exp(-1));
        @(negedge clk);
        start = 1'b0;
        compare_out();
    endtask

    task automatic do_tick(input bit bv, input int bx1, input int bx2, input int by1, input int by2);
        int hi;
        int spawn;
        bit go;
        @(negedge clk);
        move_tick = 1'b1;
        bullet_valid = bv;
        bullet_x1 = 10'(bx1);
        bullet_x2 = 10'(bx2);
        bullet_y1 = 11'(by1);
        bullet_y2 = 11'(by2);
        hi = -1;
        go = 1'b0;
        if (m_state == S_PLAY) begin
            for (int i = 0; i < N; i++)
                if (hi < 0 && bv && bx2 > m_x[i] && bx1 < m_x[i] + SIZE &&
                    by1 < m_y[i] + SIZE && by2 > m_y[i])
                    hi = i;
            spawn = (int'(m_lfsr) < SPAN) ? int'(m_lfsr) : int'(m_lfsr) - SPAN;
            for (int i = 0; i < N; i++) begin
                if (i == hi) begin
                    m_y[i] = -SIZE;
                    m_x[i] = spawn;
                end else begin
                    m_y[i] = m_y[i] + SPEED;
                    if (m_y[i] >= GROUND) go = 1'b1;
                end
            end
            if (hi >= 0 && m_score < 99) m_score++;
            if (go) m_state = S_OVER;
        end
        sb.push_back(make_exp(hi));
        @(negedge clk);
        move_tick = 1'b0;
        bullet_valid = 1'b0;
        compare_out();
    endtask

    task automatic query(input int qx, input int qy);
        pix_t p;
        int found;
        @(negedge clk);
        px = 10'(qx);
        py = 10'(qy);
        found = -1;
        if (m_state != S_IDLE)
            for (int i = 0; i < N; i++)
                if (found < 0 && qx > m_x[i] && qx < m_x[i] + SIZE && qy > m_y[i] && qy < m_y[i] + SIZE)
                    found = i;
        p.obj = (found >= 0);
        p.idx = (found >= 0) ? 3'(found) : 3'd0;
        pq.push_back(p);
        @(negedge clk);
        check_value("pix_depth", 32'(pq.size()), 32'd1);
        if (pq.size() > 0) begin
            p = pq.pop_front();
            check_value("pix_obj", 32'(pix_obj), 32'(p.obj));
            if (p.obj)
                check_value("pix_idx", 32'(pix_idx), 32'(p.idx));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; move_tick = 1'b0; bullet_valid = 1'b0;
        bullet_x1 = '0; bullet_x2 = '0; bullet_y1 = '0; bullet_y2 = '0;
        px = '0; py = '0;
        m_state = S_IDLE; m_score = 0;
        model_init();

        do_reset();
        check_value("reset_pix_obj", 32'(pix_obj), 32'd0);
        check_value("reset_pix_idx", 32'(pix_idx), 32'd0);
        query(110, 5);

        do_start();
        repeat (10) do_tick(1'b0, 0, 0, 0, 0);
        query(110, 9);
        query(110, 10);

        do_tick(1'b1, 105, 111, -20, -10);
        check_value("first_hit_score_ones", 32'(score_ones), 32'd1);
        repeat (10) do_tick(1'b0, 0, 0, 0, 0);
        query(m_x[0] + 1, 0);
        query(m_x[0], 0);

        do_tick(1'b1, 200, 290, -150, -60);
        check_value("double_overlap_idx", 32'(hit_idx), 32'd1);
        query(m_x[2] + 5, 0);
        do_start();

        repeat (97) do_tick(1'b1, 0, 1023, -1000, 1000);
        check_value("score_99", 32'({score_tens, score_ones}), 32'h99);
        do_tick(1'b1, 0, 1023, -1000, 1000);
        check_value("sat_hit_pulse", 32'(hit), 32'd1);
        check_value("sat_score", 32'({score_tens, score_ones}), 32'h99);

        for (int n = 0; n < 600 && m_state != S_OVER; n++)
            do_tick(1'b0, 0, 0, 0, 0);
        check_value("over_reached", 32'(game_over), 32'd1);
        repeat (2) do_tick(1'b1, 0, 1023, -1000, 1000);
        query(m_x[1] + 5, m_y[1] + 5);
        query(m_x[2] + 5, m_y[2] + 5);

        do_start();
        repeat (100) do_tick(1'b0, 0, 0, 0, 0);
        query(110, 80);
        query(100, 80);
        repeat (374) do_tick(1'b0, 0, 0, 0, 0);
        check_value("pre_ground_playing", 32'(playing), 32'd1);
        do_tick(1'b1, 195, 200, 380, 390);
        check_value("ground_with_hit_over", 32'(game_over), 32'd1);
        check_value("ground_with_hit_idx", 32'(hit_idx), 32'd1);

        do_start();
        @(negedge clk);
        move_tick = 1'b1; bullet_valid = 1'b1;
        bullet_x1 = 10'd0; bullet_x2 = 10'd1023;
        bullet_y1 = -11'sd1000; bullet_y2 = 11'sd1000;
        reset = 1'b1;
        model_init();
        m_state = S_IDLE;
        m_score = 0;
        sb.push_back(make_exp(-1));
        @(negedge clk);
        move_tick = 1'b0; bullet_valid = 1'b0; reset = 1'b0;
        compare_out();
        query(110, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/asteroid_field.md
Name: asteroid_field

Overview:
- Parametrised successor to the single-screen asteroid logic: owns N_AST falling asteroids, with collision against one bullet box, LFSR respawn, a BCD score and a game state machine.
- Sits between the input/bullet logic and the VGA colour mux.
- Adds a pixel-lookup port so the renderer asks "which object is at (px,py)" instead of holding per-asteroid coordinates.

Parameters:
- N_AST, 4, number of asteroids (1..8).
- SIZE, 25, asteroid edge length in pixels.
- SPEED, 1, pixels moved per move_tick.
- SCREEN_W, 640, playfield width; spawn x range is 0..SCREEN_W-SIZE-1.
- GROUND_Y, 450, y1 value at or beyond which an asteroid ends the game.
- X0, 100, x1 of asteroid 0 at start.
- X_STEP, 90, x1 spacing between consecutive asteroids at start.
- Y_STAGGER, 75, extra vertical offset per index at start.
- LFSR_SEED, 9'h1A5, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; starts or restarts a game from IDLE or OVER
- move_tick  in  1  one-cycle enable; advances the playfield
- bullet_valid  in  1  bullet box below is live
- bullet_x1, bullet_x2  in  10 each  bullet horizontal bounds, exclusive
- bullet_y1, bullet_y2  in  11 signed each  bullet vertical bounds, exclusive
- px, py  in  10 each  renderer pixel query
- pix_obj  out  1  an asteroid covers the queried pixel (registered)
- pix_idx  out  3  index of that asteroid, lowest index wins
- hit  out  1  one-cycle pulse when a bullet destroys an asteroid
- hit_idx  out  3  index destroyed; valid with hit
- bullet_kill  out  1  one-cycle pulse, coincident with hit; bullet owner must clear its bullet
- score_ones, score_tens  out  4 each  BCD score
- game_over  out  1  high while in OVER
- playing  out  1  high while in PLAY

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - LFSR = LFSR_SEED.
  - Asteroid i: x1 = X0 + i*X_STEP, y1 = -SIZE - i*Y_STAGGER.
- Coordinates:
  - x1 is 10-bit unsigned; y1 is 11-bit signed. x2 = x1+SIZE and y2 = y1+SIZE are derived, not stored.
- LFSR:
  - 9-bit, next = {q[7:0], q[8]^q[6]^q[5]^q[4]}; advances every clk in every state.
  - Spawn x = q if q < SCREEN_W-SIZE, else q-(SCREEN_W-SIZE).
- State machine:
  - IDLE: start -> PLAY. On entry, asteroid positions are loaded to their start values and the score is cleared.
  - PLAY: move_tick performs the update below. Any post-move y1 >= GROUND_Y -> OVER on the next cycle.
  - OVER: asteroids frozen; start -> PLAY with the same initialisation as from IDLE.
  - move_tick is ignored in IDLE and OVER; start is ignored in PLAY.
- Tick update (PLAY and move_tick, single cycle):
  - Collision test uses pre-tick positions. Overlap is strict: bx2>ax1 & bx1<ax2 & by1<ay2 & by2>ay1, gated by bullet_valid.
  - At most one hit per tick; the lowest-index colliding asteroid wins, others are untouched this tick.
  - Hit asteroid: y1 <= -SIZE, x1 <= spawn x from the current LFSR value. The asteroid does not move this tick.
  - All other asteroids: y1 <= y1 + SPEED.
  - On a hit, hit, hit_idx and bullet_kill are registered and assert the cycle after the tick. The score increments in that same cycle.
- Score:
  - BCD: ones 9 -> 0 with tens+1.
  - Saturates at 99; hit still pulses at 99.
- Game-over check:
  - Uses post-move y1 of every asteroid. A respawned asteroid never triggers it.
  - A simultaneous hit on one asteroid and a ground crossing by another still goes to OVER, and the hit is still scored.
- Pixel lookup:
  - pix_obj/pix_idx are registered, 1-cycle latency from px/py. The test is strict interior (px>x1 & px<x2 & py>y1 & py<y2) with lowest index winning.
  - Active in PLAY and OVER (frozen field visible); 0 in IDLE.
- Reset mid-game: returns everything to reset values on the next edge; any pending hit pulse is dropped.

Decomposition:
- Shared package field_pkg:
  - coordinate widths (XW=10, YW=11);
  - state enum {IDLE, PLAY, OVER};
  - BCD increment function;
  - LFSR taps constant.
- One natural sub-module: asteroid_slot, instantiated N_AST times. It holds x1/y1, a move/respawn load, and the overlap and pixel compare outputs.
- A priority encoder selects hit_idx and pix_idx.

Test Plan:
- Reset, start, then 10 move_ticks with no bullet -> asteroid 0 y1 = -25+10 = -15; score 00; no hit.
- Bullet box x 105..111, y -20..-10 over asteroid 0 (x1=100) at y1=-15 on a tick -> hit=1, hit_idx=0, bullet_kill=1 the next cycle; ones=1; asteroid 0 y1=-25 with x1 = spawn from LFSR.
- Bullet overlapping asteroids 1 and 2 simultaneously -> hit_idx=1 only; asteroid 2 moves by SPEED; score +1.
- Drive 99 hits, then one more -> score stays 9/9 and hit still pulses; check the 09 -> 10 BCD carry on the way.
- Tick until asteroid 0 y1 reaches 450 -> game_over=1 next cycle; further ticks leave positions unchanged; start -> playing=1 with start positions restored and score 00.
- Query px=110, py=y1+5 of asteroid 0 -> pix_obj=1, pix_idx=0 one cycle later; px=x1 exactly -> pix_obj=0 (strict boundary).
